// File: rtl/mapu_n_pkg.sv
// Shared types and element-range helpers for the N x N matrix APU.
package mapu_n_pkg;

  typedef enum logic [1:0] {
    MAPU_OP_ADD  = 2'd0,
    MAPU_OP_SUB  = 2'd1,
    MAPU_OP_EMUL = 2'd2,
    MAPU_OP_MMUL = 2'd3
  } mapu_op_e;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    DRAIN  = 2'd2
  } mapu_state_e;

  // Wide enough for any accumulator width the block can be configured with.
  localparam int MAPU_WIDE = 128;

  function automatic logic signed [MAPU_WIDE-1:0] elemMax(input int dw);
    logic signed [MAPU_WIDE-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return (one <<< (dw - 1)) - one;
  endfunction

  function automatic logic signed [MAPU_WIDE-1:0] elemMin(input int dw);
    logic signed [MAPU_WIDE-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return -(one <<< (dw - 1));
  endfunction

endpackage

// File: rtl/mapu_n_if.sv
// Row-streaming bundle for the matrix APU: operand rows in, result rows out,
// each direction with its own valid/ready pair.
interface mapu_n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 3
);
  import mapu_n_pkg::*;

  logic                    i_en;
  mapu_op_e                i_op;
  logic                    i_vld;
  logic                    o_rdy;
  logic [N*DATA_WIDTH-1:0] i_row;
  logic                    o_vld;
  logic                    i_rdy;
  logic [N*DATA_WIDTH-1:0] o_row;
  logic                    o_of;

  modport master (
    output i_en, i_op, i_vld, i_row, i_rdy,
    input  o_rdy, o_vld, o_row, o_of
  );

  modport slave (
    input  i_en, i_op, i_vld, i_row, i_rdy,
    output o_rdy, o_vld, o_row, o_of
  );

endinterface

// File: rtl/mapu_n_row_alu.sv
// Combinational result generator for one output row: element-wise ops use
// B row rowIdx_i, matrix multiply walks the full B matrix.
module mapu_n_row_alu
  import mapu_n_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 3,
  parameter int SATURATE   = 0
) (
  input  logic [N-1:0][DATA_WIDTH-1:0]        aRow_i,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] bMat_i,
  input  logic [$clog2(N)-1:0]                rowIdx_i,
  input  mapu_op_e                            op_i,
  output logic [N-1:0][DATA_WIDTH-1:0]        res_o,
  output logic                                rowOf_o
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(N);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(elemMax(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(elemMin(DATA_WIDTH));

  logic signed [ACC_W-1:0] full;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_W-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Every op is evaluated at accumulator width so overflow is judged on the
  // exact result before narrowing.
  always_comb begin
    res_o   = '0;
    rowOf_o = 1'b0;
    full    = '0;
    for (int j = 0; j < N; j++) begin
      full = '0;
      case (op_i)
        MAPU_OP_ADD:  full = sext(aRow_i[j]) + sext(bMat_i[rowIdx_i][j]);
        MAPU_OP_SUB:  full = sext(aRow_i[j]) - sext(bMat_i[rowIdx_i][j]);
        MAPU_OP_EMUL: full = sext(aRow_i[j]) * sext(bMat_i[rowIdx_i][j]);
        default: begin
          for (int k = 0; k < N; k++) begin
            full = full + sext(aRow_i[k]) * sext(bMat_i[k][j]);
          end
        end
      endcase
      if (full > MAX_V) begin
        rowOf_o  = 1'b1;
        res_o[j] = (SATURATE != 0) ? MAX_V[DATA_WIDTH-1:0] : full[DATA_WIDTH-1:0];
      end else if (full < MIN_V) begin
        rowOf_o  = 1'b1;
        res_o[j] = (SATURATE != 0) ? MIN_V[DATA_WIDTH-1:0] : full[DATA_WIDTH-1:0];
      end else begin
        res_o[j] = full[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mapu_n.sv
// Matrix APU top: loads A then B row by row, then drains result rows through
// a single row ALU indexed by the drain counter.
module mapu_n
  import mapu_n_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 3,
  parameter int SATURATE   = 0
) (
  input logic     clk,
  input logic     reset_n,
  mapu_n_if.slave bus
);

  localparam int              CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef logic [N-1:0][DATA_WIDTH-1:0]        row_t;
  typedef logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;

  mapu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  mapu_op_e         op_q;
  mat_t             aMat_q, aMat_d;
  mat_t             bMat_q, bMat_d;
  logic             oVld_q;
  logic             oOf_q;
  row_t             oRow_q;

  logic             rdy;
  logic             accept;
  logic [CNT_W-1:0] aluIdx;
  row_t             aluRes;
  logic             aluOf;

  assign rdy       = reset_n & bus.i_en & (state_q != DRAIN);
  assign accept    = bus.i_vld & rdy;
  assign bus.o_rdy = rdy;
  assign bus.o_vld = oVld_q;
  assign bus.o_row = oRow_q;
  assign bus.o_of  = oOf_q;

  // The ALU sees B including the beat being accepted, so row 0 can be
  // registered on the same edge as the final B row.
  always_comb begin
    aMat_d = aMat_q;
    bMat_d = bMat_q;
    if (accept && state_q == LOAD_A) aMat_d[cnt_q] = bus.i_row;
    if (accept && state_q == LOAD_B) bMat_d[cnt_q] = bus.i_row;
  end

  assign aluIdx = (state_q == DRAIN && cnt_q != LAST) ? cnt_q + CNT_W'(1) : '0;

  mapu_n_row_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .SATURATE   (SATURATE)
  ) u_alu (
    .aRow_i   (aMat_q[aluIdx]),
    .bMat_i   (bMat_d),
    .rowIdx_i (aluIdx),
    .op_i     (op_q),
    .res_o    (aluRes),
    .rowOf_o  (aluOf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      op_q    <= MAPU_OP_ADD;
      aMat_q  <= '0;
      bMat_q  <= '0;
      oVld_q  <= 1'b0;
      oOf_q   <= 1'b0;
      oRow_q  <= '0;
    end else begin
      aMat_q <= aMat_d;
      bMat_q <= bMat_d;
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            if (cnt_q == '0) op_q <= bus.i_op;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_B;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
              oVld_q  <= 1'b1;
              oRow_q  <= aluRes;
              oOf_q   <= aluOf;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // Output holds while the consumer stalls; each accepted row loads the next.
          if (oVld_q && bus.i_rdy) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= LOAD_A;
              oVld_q  <= 1'b0;
            end else begin
              cnt_q  <= cnt_q + CNT_W'(1);
              oRow_q <= aluRes;
              oOf_q  <= aluOf;
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

endmodule
